// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory bus controller: funct3 size/sign
// encodings, FSM state encoding and the alignment check.
package dm_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } dm_state_t;

  // Halves need an even address, words (and any unlisted code) a 4-aligned one.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lo);
    case (f3)
      F3_B, F3_BU: is_misaligned = 1'b0;
      F3_H, F3_HU: is_misaligned = lo[0];
      default:     is_misaligned = (lo != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/dm_lane_align.sv
// Byte-lane alignment: store strobes and data replication, load byte/half
// select with sign or zero extension. Purely combinational.
module dm_lane_align
  import dm_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rword,
  output logic [3:0]  o_wstrb,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Pick the addressed byte and half out of the read word.
  always_comb begin
    case (i_addr_lo)
      2'd0:    w_byte = i_rword[7:0];
      2'd1:    w_byte = i_rword[15:8];
      2'd2:    w_byte = i_rword[23:16];
      default: w_byte = i_rword[31:24];
    endcase
    w_half = i_addr_lo[1] ? i_rword[31:16] : i_rword[15:0];
  end

  // Store strobes/replication and load extension by access size.
  always_comb begin
    // NOTE: every output gets a default first, so no path can leave one unassigned and infer a latch.
    o_wstrb = 4'b1111;
    o_wdata = i_wdata;
    o_rdata = i_rword;
    case (i_funct3)
      F3_B, F3_BU: begin
        o_wstrb = 4'b0001 << i_addr_lo;
        o_wdata = {4{i_wdata[7:0]}};
      end
      F3_H, F3_HU: begin
        o_wstrb = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wdata = {2{i_wdata[15:0]}};
      end
      default: ;
    endcase
    case (i_funct3)
      F3_B:    o_rdata = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_rdata = {24'h0, w_byte};
      F3_H:    o_rdata = {{16{w_half[15]}}, w_half};
      F3_HU:   o_rdata = {16'h0, w_half};
      default: ;
    endcase
  end

endmodule

// File: rtl/dm_bus_ctrl.sv
// MA-stage data-memory access controller: one load/store at a time over a
// req/ready bus, ending with a one-cycle dm_ack to the hold unit.
// Optional build macro DM_TIMEOUT_EN: abort REQ with bus_err after
// TIMEOUT_CYCLES cycles without bus_ready.
module dm_bus_ctrl
  import dm_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata_out,
  output logic              dm_ack,
  output logic              misalign,
  output logic              bus_err,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_wstrb,
  output logic [31:0]       bus_wdata,
  input  logic [31:0]       bus_rdata,
  input  logic              bus_ready
);

  dm_state_t         r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [2:0]        r_funct3;
  logic              r_we;
  logic              r_bus_req;
  logic              r_dm_ack;
  logic              r_misalign;
  logic              r_bus_err;
  logic [31:0]       r_rdata;

  logic [3:0]        w_wstrb;
  logic [31:0]       w_wdata_rep;
  logic [31:0]       w_rdata_ext;
  logic              w_timeout;

  // Lane logic runs off the latched request, so bus outputs stay stable in REQ.
  dm_lane_align u_align (
    .i_funct3  (r_funct3),
    .i_addr_lo (r_addr[1:0]),
    .i_wdata   (r_wdata),
    .i_rword   (bus_rdata),
    .o_wstrb   (w_wstrb),
    .o_wdata   (w_wdata_rep),
    .o_rdata   (w_rdata_ext)
  );

`ifdef DM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] r_tmo_cnt;

  // Count REQ cycles without bus_ready; held at zero outside REQ so it starts clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 r_tmo_cnt <= '0;
    else if (r_state != REQ) r_tmo_cnt <= '0;
    else if (!bus_ready)     r_tmo_cnt <= r_tmo_cnt + 1'b1;
  end

  assign w_timeout = (r_state == REQ) && !bus_ready &&
                     (r_tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
  assign w_timeout        = 1'b0;
`endif

  // Transaction FSM with registered bus request and response outputs.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments so every register here samples pre-edge values.
    if (rst) begin
      r_state    <= IDLE;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_funct3   <= '0;
      r_we       <= 1'b0;
      r_bus_req  <= 1'b0;
      r_dm_ack   <= 1'b0;
      r_misalign <= 1'b0;
      r_bus_err  <= 1'b0;
      r_rdata    <= '0;
    end else begin
      r_dm_ack   <= 1'b0;
      r_misalign <= 1'b0;
      r_bus_err  <= 1'b0;
      r_rdata    <= '0;
      case (r_state)
        IDLE: begin
          if (mem_rd || mem_wr) begin
            if (is_misaligned(funct3, addr[1:0])) begin
              r_state    <= RESP;
              r_dm_ack   <= 1'b1;
              r_misalign <= 1'b1;
            end else begin
              r_state   <= REQ;
              r_addr    <= addr;
              r_wdata   <= wdata;
              r_funct3  <= funct3;
              r_we      <= mem_wr;
              r_bus_req <= 1'b1;
            end
          end
        end
        REQ: begin
          if (bus_ready) begin
            r_state   <= RESP;
            r_bus_req <= 1'b0;
            r_dm_ack  <= 1'b1;
            r_rdata   <= r_we ? 32'h0 : w_rdata_ext;
          end else if (w_timeout) begin
            r_state   <= RESP;
            r_bus_req <= 1'b0;
            r_dm_ack  <= 1'b1;
            r_bus_err <= 1'b1;
          end
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign dm_ack    = r_dm_ack;
  assign misalign  = r_misalign;
  assign bus_err   = r_bus_err;
  assign rdata_out = r_rdata;
  assign bus_req   = r_bus_req;
  assign bus_we    = r_we;
  assign bus_addr  = {r_addr[ADDR_W-1:2], 2'b00};
  assign bus_wstrb = r_we ? w_wstrb : 4'b0000;
  assign bus_wdata = w_wdata_rep;

endmodule

// File: tb/tb_dm_bus_ctrl.sv
// Directed self-checking bench for dm_bus_ctrl. Inputs change 1 time unit
// after a rising edge; outputs are sampled there too, away from the edge.
module tb_dm_bus_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_rd = 1'b0;
  logic        mem_wr = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rdata_out;
  logic        dm_ack;
  logic        misalign;
  logic        bus_err;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata = 32'h0;
  logic        bus_ready = 1'b0;

  int checks   = 0;
  int failures = 0;

  dm_bus_ctrl #(.ADDR_W(32), .TIMEOUT_CYCLES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .funct3    (funct3),
    .addr      (addr),
    .wdata     (wdata),
    .rdata_out (rdata_out),
    .dm_ack    (dm_ack),
    .misalign  (misalign),
    .bus_err   (bus_err),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wstrb (bus_wstrb),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .bus_ready (bus_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Aligned load, bus_ready in the first REQ cycle: bus_req cycle 1, dm_ack cycle 2.
  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] exp_addr, input logic [31:0] word,
                         input logic [31:0] exp);
    mem_rd = 1'b1; mem_wr = 1'b0; funct3 = f3; addr = a;
    bus_rdata = word; bus_ready = 1'b0;
    step();
    check({tag, ".req"},   32'(bus_req),   32'd1);
    check({tag, ".addr"},  bus_addr,       exp_addr);
    check({tag, ".wstrb"}, 32'(bus_wstrb), 32'h0);
    check({tag, ".ack0"},  32'(dm_ack),    32'd0);
    bus_ready = 1'b1;
    step();
    check({tag, ".ack"},   32'(dm_ack),    32'd1);
    check({tag, ".rdata"}, rdata_out,      exp);
    check({tag, ".reqlo"}, 32'(bus_req),   32'd0);
    mem_rd = 1'b0; bus_ready = 1'b0; bus_rdata = 32'h0;
    step();
    check({tag, ".ackoff"}, 32'(dm_ack),   32'd0);
    check({tag, ".rd0"},    rdata_out,     32'h0);
  endtask

  // Misaligned access: dm_ack+misalign in cycle 1, never a bus request.
  task automatic do_misalign(input string tag, input logic rd, input logic wr,
                             input logic [2:0] f3, input logic [31:0] a);
    mem_rd = rd; mem_wr = wr; funct3 = f3; addr = a; wdata = 32'hCAFEF00D;
    step();
    check({tag, ".ack"},   32'(dm_ack),   32'd1);
    check({tag, ".mis"},   32'(misalign), 32'd1);
    check({tag, ".req"},   32'(bus_req),  32'd0);
    check({tag, ".rdata"}, rdata_out,     32'h0);
    mem_rd = 1'b0; mem_wr = 1'b0;
    step();
    check({tag, ".ackoff"}, 32'(dm_ack),  32'd0);
    check({tag, ".misoff"}, 32'(misalign), 32'd0);
    check({tag, ".req2"},   32'(bus_req), 32'd0);
  endtask

  initial begin
    // Reset state
    step();
    check("rst.ack",   32'(dm_ack),    32'd0);
    check("rst.req",   32'(bus_req),   32'd0);
    check("rst.rdata", rdata_out,      32'h0);
    check("rst.addr",  bus_addr,       32'h0);
    check("rst.wstrb", 32'(bus_wstrb), 32'h0);
    check("rst.wdata", bus_wdata,      32'h0);
    check("rst.we",    32'(bus_we),    32'd0);
    check("rst.flags", {30'h0, misalign, bus_err}, 32'h0);
    rst = 1'b0;
    step();

    // Loads: word, signed/unsigned byte, unsigned/signed half
    check("lw.pre_req", 32'(bus_req), 32'd0);
    do_load("lw",  3'b010, 32'h100, 32'h100, 32'hDEADBEEF, 32'hDEADBEEF);
    do_load("lb",  3'b000, 32'h103, 32'h100, 32'h80FF0000, 32'hFFFFFF80);
    do_load("lbu", 3'b100, 32'h103, 32'h100, 32'h80FF0000, 32'h00000080);
    do_load("lhu", 3'b101, 32'h102, 32'h100, 32'h80FF0000, 32'h000080FF);
    do_load("lh",  3'b001, 32'h102, 32'h100, 32'h80FF0000, 32'hFFFF80FF);
    do_load("lb0", 3'b000, 32'h104, 32'h104, 32'h1234567F, 32'h0000007F);

    // SB addr=0x201, ready delayed 3 cycles; inputs disturbed during REQ
    mem_wr = 1'b1; mem_rd = 1'b0; funct3 = 3'b000; addr = 32'h201; wdata = 32'h12345678;
    step();
    addr = 32'h3FF; wdata = 32'hFFFFFFFF; funct3 = 3'b010;
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("sb.req%0d", i),   32'(bus_req),   32'd1);
      check($sformatf("sb.we%0d", i),    32'(bus_we),    32'd1);
      check($sformatf("sb.strb%0d", i),  32'(bus_wstrb), 32'b0010);
      check($sformatf("sb.wdata%0d", i), bus_wdata,      32'h78787878);
      check($sformatf("sb.addr%0d", i),  bus_addr,       32'h200);
      check($sformatf("sb.ack%0d", i),   32'(dm_ack),    32'd0);
      if (i == 4) bus_ready = 1'b1;
      step();
    end
    check("sb.ack",   32'(dm_ack),  32'd1);
    check("sb.rdata", rdata_out,    32'h0);
    check("sb.reqlo", 32'(bus_req), 32'd0);
    mem_wr = 1'b0; bus_ready = 1'b0;
    step();

    // SH upper half
    mem_wr = 1'b1; funct3 = 3'b001; addr = 32'h202; wdata = 32'h5555ABCD;
    step();
    check("sh.strb",  32'(bus_wstrb), 32'b1100);
    check("sh.wdata", bus_wdata,      32'hABCDABCD);
    bus_ready = 1'b1;
    step();
    check("sh.ack", 32'(dm_ack), 32'd1);
    mem_wr = 1'b0; bus_ready = 1'b0;
    step();

    // mem_rd and mem_wr together act as a word write
    mem_rd = 1'b1; mem_wr = 1'b1; funct3 = 3'b010; addr = 32'h300; wdata = 32'hA5A5_0F0F;
    bus_rdata = 32'h11111111;
    step();
    check("rw.we",    32'(bus_we),    32'd1);
    check("rw.strb",  32'(bus_wstrb), 32'b1111);
    check("rw.wdata", bus_wdata,      32'hA5A50F0F);
    bus_ready = 1'b1;
    step();
    check("rw.ack",   32'(dm_ack), 32'd1);
    check("rw.rdata", rdata_out,   32'h0);
    mem_rd = 1'b0; mem_wr = 1'b0; bus_ready = 1'b0; bus_rdata = 32'h0;
    step();

    // Misaligned accesses, including an unlisted funct3 treated as word
    do_misalign("mis_lw", 1'b1, 1'b0, 3'b010, 32'h102);
    do_misalign("mis_sh", 1'b0, 1'b1, 3'b001, 32'h101);
    do_misalign("mis_f3", 1'b1, 1'b0, 3'b011, 32'h101);

    // Back-to-back: request held through RESP is taken only in the next IDLE
    mem_rd = 1'b1; funct3 = 3'b010; addr = 32'h400; bus_rdata = 32'h0BADF00D;
    step();
    bus_ready = 1'b1;
    step();
    check("b2b.ack1", 32'(dm_ack), 32'd1);
    addr = 32'h500; bus_ready = 1'b0; bus_rdata = 32'h600DCAFE;
    step();
    check("b2b.idle_req", 32'(bus_req), 32'd0);
    check("b2b.idle_ack", 32'(dm_ack),  32'd0);
    step();
    check("b2b.req2",  32'(bus_req), 32'd1);
    check("b2b.addr2", bus_addr,     32'h500);
    bus_ready = 1'b1;
    step();
    check("b2b.ack2",   32'(dm_ack), 32'd1);
    check("b2b.rdata2", rdata_out,   32'h600DCAFE);
    mem_rd = 1'b0; bus_ready = 1'b0;
    step();

`ifdef DM_TIMEOUT_EN
    // Timeout after 4 REQ cycles
    mem_rd = 1'b1; funct3 = 3'b010; addr = 32'h600; bus_rdata = 32'hFFFFFFFF;
    step();
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("tmo.req%0d", i), 32'(bus_req), 32'd1);
      check($sformatf("tmo.ack%0d", i), 32'(dm_ack),  32'd0);
      step();
    end
    check("tmo.ack",   32'(dm_ack),  32'd1);
    check("tmo.err",   32'(bus_err), 32'd1);
    check("tmo.rdata", rdata_out,    32'h0);
    check("tmo.reqlo", 32'(bus_req), 32'd0);
    mem_rd = 1'b0;
    step();
    check("tmo.erroff", 32'(bus_err), 32'd0);
    // bus_ready on the timeout edge wins
    mem_rd = 1'b1; bus_rdata = 32'h13579BDF;
    step();
    for (int i = 1; i <= 4; i++) begin
      if (i == 4) bus_ready = 1'b1;
      step();
    end
    check("tmo_win.ack",   32'(dm_ack),  32'd1);
    check("tmo_win.err",   32'(bus_err), 32'd0);
    check("tmo_win.rdata", rdata_out,    32'h13579BDF);
    mem_rd = 1'b0; bus_ready = 1'b0;
    step();
`else
    // Without the timeout, REQ waits indefinitely and bus_err stays low
    mem_rd = 1'b1; funct3 = 3'b010; addr = 32'h600; bus_rdata = 32'h2468ACE0;
    step();
    for (int i = 1; i <= 8; i++) step();
    check("wait.req", 32'(bus_req), 32'd1);
    check("wait.ack", 32'(dm_ack),  32'd0);
    check("wait.err", 32'(bus_err), 32'd0);
    bus_ready = 1'b1;
    step();
    check("wait.done",  32'(dm_ack), 32'd1);
    check("wait.rdata", rdata_out,   32'h2468ACE0);
    check("wait.err2",  32'(bus_err), 32'd0);
    mem_rd = 1'b0; bus_ready = 1'b0;
    step();
`endif

    // Asynchronous reset during REQ
    mem_rd = 1'b1; funct3 = 3'b010; addr = 32'h700; bus_rdata = 32'h77777777;
    step();
    check("arst.req_before", 32'(bus_req), 32'd1);
    #2;
    rst = 1'b1; mem_rd = 1'b0;
    #1;
    check("arst.req_drop", 32'(bus_req),  32'd0);
    check("arst.ack",      32'(dm_ack),   32'd0);
    check("arst.addr",     bus_addr,      32'h0);
    bus_ready = 1'b1;
    step();
    rst = 1'b0;
    step();
    check("arst.noack", 32'(dm_ack),  32'd0);
    check("arst.noreq", 32'(bus_req), 32'd0);
    bus_ready = 1'b0;
    do_load("post_rst", 3'b010, 32'h100, 32'h100, 32'hDEADBEEF, 32'hDEADBEEF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
